l2_bank_rr_arbiter: RTL and testbench

- Request-side scheduler for one L2 memory bank shared by N_MASTER crossbar masters.
- Each cycle, picks at most one requesting master by round-robin and forwards its transaction to the bank.
- Tracks the winner's one-hot ID through the bank's fixed read latency.
- Emits response valid + one-hot ID in the form consumed by the L2 response decoder, which fans r_valid back to masters.

---
 rtl/l2_arb_pkg.sv | 36 +++
 rtl/l2_rr_prio_sel.sv | 31 +++
 rtl/l2_bank_rr_arbiter.sv | 112 +++++++++++
 tb/tb_l2_bank_rr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared defaults, one-hot ID type and index/one-hot conversion helpers for the L2 bank arbiter.
package l2_arb_pkg;

    localparam int unsigned N_MASTER_DEF     = 8;
    localparam int unsigned ADDR_WIDTH_DEF   = 12;
    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned RESP_LATENCY_DEF = 1;

    // Helpers work on a fixed maximum width; callers size-cast to their own N_MASTER.
    localparam int unsigned MAX_MASTER = 32;
    localparam int unsigned MAX_IDX_W  = 6;

    typedef logic [MAX_MASTER-1:0] id_vec_t;
    typedef logic [MAX_IDX_W-1:0]  idx_t;

    function automatic id_vec_t idx_to_onehot(input idx_t idx);
        id_vec_t oh;
        oh = '0;
        for (int i = 0; i < int'(MAX_MASTER); i++) begin
            oh[i] = (idx == idx_t'(i));
        end
        return oh;
    endfunction

    function automatic idx_t onehot_to_idx(input id_vec_t oh);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_MASTER); i++) begin
            if (oh[i]) begin
                idx = idx | idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/l2_rr_prio_sel.sv
// Combinational rotate-priority select: first requester at or after ptr_i, wrapping modulo N_MASTER.
module l2_rr_prio_sel #(
    parameter  int unsigned N_MASTER = 8,
    localparam int unsigned IDX_W    = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    logic [IDX_W:0] cand;

    // NOTE: every variable gets a default at the top of the block, so no path leaves one holding its old value (no latch).
    always_comb begin
        idx_o   = '0;
        cand    = '0;
        valid_o = |req_i;
        // Walk from the farthest offset toward the pointer so the nearest requester is written last and wins.
        for (int k = int'(N_MASTER) - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTER)) begin
                cand = cand - (IDX_W+1)'(N_MASTER);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                idx_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin request scheduler for one L2 bank: picks one master per cycle, forwards its payload,
// and carries the winner's one-hot ID through the bank read latency to the response decoder.
module l2_bank_rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTER     = N_MASTER_DEF,
    parameter int unsigned ID_WIDTH     = N_MASTER,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned RESP_LATENCY = RESP_LATENCY_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic                                 bank_req_o,
    output logic [ADDR_WIDTH-1:0]                bank_add_o,
    output logic                                 bank_wen_o,
    output logic [DATA_WIDTH-1:0]                bank_wdata_o,
    output logic [BE_WIDTH-1:0]                  bank_be_o,
    input  logic                                 bank_gnt_i,
    input  logic [DATA_WIDTH-1:0]                bank_rdata_i,
    output logic                                 data_r_valid_o,
    output logic [ID_WIDTH-1:0]                  data_r_ID_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o
);

    localparam int unsigned IDX_W = $clog2(N_MASTER);

    if (ID_WIDTH != N_MASTER) begin : g_bad_id_width
        $error("l2_bank_rr_arbiter: ID_WIDTH must equal N_MASTER");
    end
    if (N_MASTER < 2 || N_MASTER > MAX_MASTER || RESP_LATENCY < 1) begin : g_bad_params
        $error("l2_bank_rr_arbiter: N_MASTER must be 2..32 and RESP_LATENCY >= 1");
    end

    logic [IDX_W-1:0]                       rr_q, rr_d;
    logic [IDX_W-1:0]                       win_idx;
    logic                                   win_valid;
    logic [ID_WIDTH-1:0]                    win_oh;
    logic                                   accept;
    logic [RESP_LATENCY-1:0][ID_WIDTH-1:0]  id_pipe_q, id_pipe_d;

    l2_rr_prio_sel #(
        .N_MASTER (N_MASTER)
    ) u_prio_sel (
        .req_i   (data_req_i),
        .ptr_i   (rr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign win_oh         = ID_WIDTH'(idx_to_onehot(idx_t'(win_idx)));
    assign accept         = win_valid & bank_gnt_i;
    assign bank_req_o     = |data_req_i;
    assign data_gnt_o     = accept ? win_oh : '0;
    assign data_r_ID_o    = id_pipe_q[RESP_LATENCY-1];
    assign data_r_valid_o = |id_pipe_q[RESP_LATENCY-1];
    assign data_r_rdata_o = bank_rdata_i;

    always_comb begin
        bank_add_o   = '0;
        bank_wen_o   = 1'b0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (win_valid) begin
            bank_add_o   = data_add_i[win_idx];
            bank_wen_o   = data_wen_i[win_idx];
            bank_wdata_o = data_wdata_i[win_idx];
            bank_be_o    = data_be_i[win_idx];
        end
    end

    // Priority only rotates on an accepted transfer; a stalled bank keeps the same head.
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (win_idx == IDX_W'(N_MASTER - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_comb begin
        id_pipe_d    = '0;
        id_pipe_d[0] = accept ? win_oh : '0;
        for (int s = 1; s < int'(RESP_LATENCY); s++) begin
            id_pipe_d[s] = id_pipe_q[s-1];
        end
    end

    // NOTE: the ID pipeline is reset, unlike a data RAM: a stale one-hot left in it would fire a phantom r_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            id_pipe_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            rr_q      <= rr_d;
            id_pipe_q <= id_pipe_d;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(data_gnt_o));
    a_rid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(data_r_ID_o));
    a_gnt_is_win:  assert property (@(posedge clk) disable iff (!rst_n)
        (|data_gnt_o) |-> (onehot_to_idx(id_vec_t'(data_gnt_o)) == idx_t'(win_idx)));

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Scoreboard bench: two arbiters (RESP_LATENCY 1 and 3, N_MASTER 4) share directed stimulus;
// per-cycle grant/payload checks are immediate, responses are checked by independent monitors.
module tb_l2_bank_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [N-1:0] id;
        int           due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         data_req;
    logic [N-1:0][AW-1:0] data_add;
    logic [N-1:0]         data_wen;
    logic [N-1:0][DW-1:0] data_wdata;
    logic [N-1:0][BW-1:0] data_be;
    logic                 bank_gnt;
    logic [DW-1:0]        bank_rdata;

    logic [N-1:0]  gnt1, gnt3, rid1, rid3;
    logic          breq1, breq3, bwen1, bwen3, rv1, rv3;
    logic [AW-1:0] badd1, badd3;
    logic [DW-1:0] bwdata1, bwdata3, rdata1, rdata3;
    logic [BW-1:0] bbe1, bbe3;

    exp_t q1[$];
    exp_t q3[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_bank_rr_arbiter #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req), .data_add_i(data_add), .data_wen_i(data_wen),
        .data_wdata_i(data_wdata), .data_be_i(data_be), .data_gnt_o(gnt1),
        .bank_req_o(breq1), .bank_add_o(badd1), .bank_wen_o(bwen1),
        .bank_wdata_o(bwdata1), .bank_be_o(bbe1), .bank_gnt_i(bank_gnt),
        .bank_rdata_i(bank_rdata), .data_r_valid_o(rv1), .data_r_ID_o(rid1),
        .data_r_rdata_o(rdata1)
    );

    l2_bank_rr_arbiter #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req), .data_add_i(data_add), .data_wen_i(data_wen),
        .data_wdata_i(data_wdata), .data_be_i(data_be), .data_gnt_o(gnt3),
        .bank_req_o(breq3), .bank_add_o(badd3), .bank_wen_o(bwen3),
        .bank_wdata_o(bwdata3), .bank_be_o(bbe3), .bank_gnt_i(bank_gnt),
        .bank_rdata_i(bank_rdata), .data_r_valid_o(rv3), .data_r_ID_o(rid3),
        .data_r_rdata_o(rdata3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Response monitors: an entry due this cycle must appear exactly now; otherwise valid and ID must be 0.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        e  = '0;
        ev = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e  = q1.pop_front();
            ev = 1'b1;
        end
        check("r1_valid", 32'(rv1), 32'(ev));
        check("r1_id", 32'(rid1), 32'(e.id));
        check("r1_rdata", rdata1, bank_rdata);
    end

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        e  = '0;
        ev = 1'b0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e  = q3.pop_front();
            ev = 1'b1;
        end
        check("r3_valid", 32'(rv3), 32'(ev));
        check("r3_id", 32'(rid3), 32'(e.id));
        check("r3_rdata", rdata3, bank_rdata);
    end

    // One cycle of stimulus; exp_win is the hand-computed winner (-1 when nobody requests).
    task automatic drive_cycle(input logic [N-1:0] req, input logic gnt, input int exp_win);
        logic [N-1:0]  exp_gnt;
        logic [AW-1:0] exp_add;
        logic          exp_wen;
        logic [DW-1:0] exp_wdata;
        logic [BW-1:0] exp_be;
        data_req   = req;
        bank_gnt   = gnt;
        bank_rdata = 32'hC0DE_0000 + 32'(cyc);
        exp_gnt    = '0;
        exp_add    = '0;
        exp_wen    = 1'b0;
        exp_wdata  = '0;
        exp_be     = '0;
        if (exp_win >= 0) begin
            exp_add   = data_add[exp_win];
            exp_wen   = data_wen[exp_win];
            exp_wdata = data_wdata[exp_win];
            exp_be    = data_be[exp_win];
            if (gnt) exp_gnt[exp_win] = 1'b1;
        end
        @(negedge clk);
        check("gnt1", 32'(gnt1), 32'(exp_gnt));
        check("gnt3", 32'(gnt3), 32'(exp_gnt));
        check("bank_req1", 32'(breq1), 32'(exp_win >= 0));
        check("bank_req3", 32'(breq3), 32'(exp_win >= 0));
        check("bank_add1", 32'(badd1), 32'(exp_add));
        check("bank_add3", 32'(badd3), 32'(exp_add));
        check("bank_wen1", 32'(bwen1), 32'(exp_wen));
        check("bank_wdata1", bwdata1, exp_wdata);
        check("bank_be1", 32'(bbe1), 32'(exp_be));
        if (exp_gnt != '0) begin
            q1.push_back(exp_t'{id: exp_gnt, due: cyc + 1});
            q3.push_back(exp_t'{id: exp_gnt, due: cyc + 3});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        data_req   = '0;
        bank_gnt   = 1'b0;
        bank_rdata = '0;
        data_wen   = '1;
        for (int i = 0; i < N; i++) begin
            data_add[i]   = AW'(32'h100 + 32'(i));
            data_wdata[i] = 32'hA000_0000 + 32'(i);
            data_be[i]    = BW'(32'd1 << i);
        end

        @(negedge clk);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        check("rst_bank_req1", 32'(breq1), 32'h0);
        check("rst_bank_add3", 32'(badd3), 32'h0);
        check("rst_rr1", 32'(u_dut1.rr_q), 32'h0);
        check("rst_rr3", 32'(u_dut3.rr_q), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All request: strict rotation 0,1,2,3,0,1,2,3 with back-to-back responses.
        for (int k = 0; k < 8; k++) drive_cycle(4'b1111, 1'b1, k % 4);

        // Move pointer to 2, then req=1010 picks 3 (wrap to 0), then 1.
        drive_cycle(4'b0010, 1'b1, 1);
        drive_cycle(4'b1010, 1'b1, 3);
        drive_cycle(4'b1010, 1'b1, 1);

        // Bank stall with pointer at 2: no grant, no rotation; then req=0011 must still pick 0.
        for (int k = 0; k < 3; k++) drive_cycle(4'b0001, 1'b0, 0);
        drive_cycle(4'b0011, 1'b1, 0);
        drive_cycle(4'b1111, 1'b1, 1);

        // Withdraw without grant, then idle with bank ready: pointer stays at 2.
        drive_cycle(4'b1000, 1'b0, 3);
        drive_cycle(4'b0000, 1'b1, -1);
        drive_cycle(4'b0101, 1'b1, 2);

        // Pointer at 3: masters 2 then 0 back-to-back.
        drive_cycle(4'b0100, 1'b1, 2);
        drive_cycle(4'b0001, 1'b1, 0);

        // Write from master 1 (pointer at 1).
        data_wen[1]   = 1'b0;
        data_add[1]   = 12'h0A5;
        data_be[1]    = 4'hF;
        data_wdata[1] = 32'hDEAD_BEEF;
        drive_cycle(4'b0010, 1'b1, 1);
        check("wr_wen3", 32'(bwen3), 32'h0);
        data_wen[1] = 1'b1;

        // Pointer at 2: master 3 then 0, then reset with two responses in flight on the latency-3 bank.
        drive_cycle(4'b1000, 1'b1, 3);
        drive_cycle(4'b0001, 1'b1, 0);
        drive_cycle(4'b0000, 1'b1, -1);
        check("pre_rst_rv3", 32'(rv3), 32'h1);
        check("pre_rst_rid3", 32'(rid3), 32'h8);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rv3", 32'(rv3), 32'h0);
        check("mid_rst_rid3", 32'(rid3), 32'h0);
        check("mid_rst_rv1", 32'(rv1), 32'h0);
        check("mid_rst_rr1", 32'(u_dut1.rr_q), 32'h0);
        check("mid_rst_rr3", 32'(u_dut3.rr_q), 32'h0);
        q1.delete();
        q3.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 4; k++) drive_cycle(4'b0000, 1'b1, -1);
        drive_cycle(4'b1111, 1'b1, 0);
        drive_cycle(4'b1111, 1'b1, 1);
        for (int k = 0; k < 4; k++) drive_cycle(4'b0000, 1'b1, -1);

        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q3_drained", 32'(q3.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
